// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester burst memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned BURST_LEN_DEF  = 4;
   localparam int unsigned BEAT_W         = $clog2(BURST_LEN_DEF);
   localparam int unsigned WORD_BYTES     = 4;

   localparam int unsigned REQ_INSTR = 0;
   localparam int unsigned REQ_DATA  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      RDATA = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not own the port last wins.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] pick_c_o
);

   always_comb begin
      pick_c_o = 2'b00;
      if (req_i[REQ_INSTR] && (!req_i[REQ_DATA] || last_i == 1'(REQ_DATA))) begin
         pick_c_o[REQ_INSTR] = 1'b1;
      end else if (req_i[REQ_DATA]) begin
         pick_c_o[REQ_DATA] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction and data cache refill/writeback bursts,
// sequencing line-aligned beats with round-robin ownership.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [1:0]                   req_i,
   input  logic [1:0]                   we_i,
   input  logic [1:0][ADDR_WIDTH-1:0]   addr_i,
   input  logic [1:0][DATA_WIDTH-1:0]   wdata_i,
   output logic [1:0]                   gnt_o,
   output logic [$clog2(BURST_LEN)-1:0] beat_o,
   output logic [1:0]                   rvalid_o,
   output logic [DATA_WIDTH-1:0]        rdata_o,
   output logic [1:0]                   done_o,
   output logic                         mem_req_o,
   output logic                         mem_we_o,
   output logic [ADDR_WIDTH-1:0]        mem_addr_o,
   output logic [DATA_WIDTH-1:0]        mem_wdata_o,
   input  logic                         mem_ready_i,
   input  logic                         mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

   localparam int unsigned           BW         = $clog2(BURST_LEN);
   localparam logic [BW-1:0]         LAST_BEAT  = BW'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BURST_LEN * WORD_BYTES - 1);

   state_e                  state_q, state_d;
   logic                    owner_q, owner_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [BW-1:0]           beat_q, beat_d;
   logic [1:0]              gnt_q, gnt_d;
   logic                    last_q, last_d;
   logic [1:0]              pick_c;

   rr_arbiter2 u_arb (
      .req_i    (req_i),
      .last_i   (last_q),
      .pick_c_o (pick_c)
   );

   // State and burst context registers; reset aborts any burst in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         base_q  <= '0;
         beat_q  <= '0;
         gnt_q   <= '0;
         last_q  <= 1'(REQ_DATA);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         base_q  <= base_d;
         beat_q  <= beat_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   // Next-state: grant capture, beat sequencing, completion.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      base_d  = base_q;
      beat_d  = beat_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_c != 2'b00) begin
               owner_d = pick_c[REQ_DATA];
               we_d    = we_i[pick_c[REQ_DATA]];
               base_d  = addr_i[pick_c[REQ_DATA]] & ALIGN_MASK;
               beat_d  = '0;
               gnt_d   = pick_c;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (mem_ready_i) begin
               if (!we_q) begin
                  state_d = RDATA;
               end else if (beat_q == LAST_BEAT) begin
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         RDATA: begin
            // Only one read beat outstanding: the next address waits for this data.
            if (mem_rvalid_i) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = DONE;
               end else begin
                  beat_d  = beat_q + BW'(1);
                  state_d = ADDR;
               end
            end
         end
         DONE: begin
            last_d  = owner_q;
            gnt_d   = '0;
            beat_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from state; write data and read return pass straight through.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      rvalid_o    = '0;
      rdata_o     = '0;
      done_o      = '0;
      case (state_q)
         ADDR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = base_q + (ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(WORD_BYTES));
            mem_wdata_o = wdata_i[owner_q];
         end
         RDATA: begin
            if (mem_rvalid_i) begin
               rvalid_o = owner_onehot(owner_q);
               rdata_o  = mem_rdata_i;
            end
         end
         DONE:    done_o = owner_onehot(owner_q);
         default: ;
      endcase
   end

   assign gnt_o  = gnt_q;
   assign beat_o = beat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a small memory model and address/data scoreboard.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned BL = 4;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [1:0]         req_i, we_i;
   logic [1:0][AW-1:0] addr_i;
   logic [1:0][DW-1:0] wdata_i;
   logic [1:0]         gnt_o, rvalid_o, done_o;
   logic [BEAT_W-1:0]  beat_o;
   logic [DW-1:0]      rdata_o, mem_wdata_o, mem_rdata_i;
   logic               mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;
   logic [AW-1:0]      mem_addr_o;

   int total = 0;
   int bad   = 0;
   int rv_cnt = 0;
   logic [DW-1:0] rd_pend = '0;
   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] exp_data[$];

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .beat_o(beat_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return a ^ 32'hC3A5_0000;
   endfunction

   // Advance one clock; memory returns read data two cycles after an accepted read beat.
   task automatic cyc(input logic rdy);
      if (rv_cnt > 0) rv_cnt--;
      if (mem_req_o && mem_ready_i && !mem_we_o) begin
         rv_cnt  = 2;
         rd_pend = mdata(mem_addr_o);
      end
      @(posedge clk_i);
      #1;
      mem_ready_i  = rdy;
      mem_rvalid_i = (rv_cnt == 1);
      mem_rdata_i  = (rv_cnt == 1) ? rd_pend : 32'hDEAD_BEEF;
      #1;
   endtask

   task automatic push_burst(input logic [AW-1:0] base, input logic rd);
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < int'(BL); i++) begin
         exp_addr.push_back(base + AW'(4 * i));
         if (rd) exp_data.push_back(mdata(base + AW'(4 * i)));
      end
   endtask

   task automatic do_reset(input logic [1:0] req);
      rst_i = 1'b0; req_i = req; we_i = '0; addr_i = '0; wdata_i = '0;
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; rv_cnt = 0;
      repeat (3) @(posedge clk_i);
      #1; rst_i = 1'b1; #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0; req_i = 2'b11; we_i = 2'b11; addr_i = '1; wdata_i = '1;
      mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = '1; rv_cnt = 0;
      repeat (3) @(posedge clk_i);
      #2;
      total++;
      if (gnt_o !== 2'b00 || beat_o !== '0 || done_o !== 2'b00 || mem_req_o !== 1'b0 ||
          mem_we_o !== 1'b0 || mem_addr_o !== '0 || rvalid_o !== 2'b00 || rdata_o !== '0) begin
         bad++;
         $display("FAIL reset_outputs gnt=%b beat=%0d done=%b req=%b we=%b addr=%h rv=%b rd=%h exp all zero",
                  gnt_o, beat_o, done_o, mem_req_o, mem_we_o, mem_addr_o, rvalid_o, rdata_o);
      end
      req_i = 2'b00; mem_rvalid_i = 1'b0; mem_ready_i = 1'b0;
      #1; rst_i = 1'b1;
      cyc(1);
      total++;
      if (gnt_o !== 2'b00 || mem_req_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle gnt=%b req=%b exp 00/0", gnt_o, mem_req_o);
      end
   endtask

   task automatic test_single_read();
      int cycles;
      bit done_seen;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cycles = 0; done_seen = 0;
      req_i = 2'b01; we_i = 2'b00; addr_i[0] = 32'h0000_1004;
      push_burst(32'h0000_1000, 1'b1);
      cyc(1);
      req_i = 2'b00;
      while (!done_seen && cycles < 60) begin
         total++;
         if (gnt_o !== 2'b01) begin bad++; $display("FAIL read_gnt got=%b exp=01", gnt_o); end
         if (mem_req_o && mem_ready_i) begin
            total++;
            if (exp_addr.size() == 0) begin bad++; $display("FAIL read_extra_beat addr=%h", mem_addr_o); end
            else begin
               ea = exp_addr.pop_front();
               if (mem_addr_o !== ea || mem_we_o !== 1'b0) begin
                  bad++; $display("FAIL read_addr got=%h we=%b exp=%h we=0", mem_addr_o, mem_we_o, ea);
               end
            end
         end
         if (rvalid_o !== 2'b00) begin
            total++;
            if (exp_data.size() == 0) begin bad++; $display("FAIL read_extra_rvalid rv=%b", rvalid_o); end
            else begin
               ed = exp_data.pop_front();
               if (rvalid_o !== 2'b01 || rdata_o !== ed) begin
                  bad++; $display("FAIL read_data rv=%b got=%h exp rv=01 data=%h", rvalid_o, rdata_o, ed);
               end
            end
         end
         if (done_o !== 2'b00) begin
            done_seen = 1; total++;
            if (done_o !== 2'b01 || exp_addr.size() != 0 || exp_data.size() != 0) begin
               bad++; $display("FAIL read_done done=%b left_addr=%0d left_data=%0d exp 01/0/0",
                               done_o, exp_addr.size(), exp_data.size());
            end
         end
         cyc(1); cycles++;
      end
      total++;
      if (!done_seen) begin bad++; $display("FAIL read_timeout cycles=%0d", cycles); end
      total++;
      if (gnt_o !== 2'b00 || done_o !== 2'b00) begin
         bad++; $display("FAIL read_after gnt=%b done=%b exp 00/00", gnt_o, done_o);
      end
   endtask

   task automatic test_write_burst();
      int k, nbeats, last_k;
      bit done_seen;
      logic [AW-1:0] ea;
      k = 0; nbeats = 0; last_k = -10; done_seen = 0;
      req_i = 2'b10; we_i = 2'b10; addr_i[1] = 32'h0000_2000;
      push_burst(32'h0000_2000, 1'b0);
      cyc(1); k = 1;
      req_i = 2'b00; we_i = 2'b00; addr_i[1] = 32'hFFFF_FFF0;
      while (!done_seen && k < 40) begin
         wdata_i[1] = $urandom; wdata_i[0] = $urandom;
         #1;
         total++;
         if (gnt_o !== 2'b10) begin bad++; $display("FAIL write_gnt got=%b exp=10", gnt_o); end
         if (mem_req_o) begin
            total++;
            if (mem_we_o !== 1'b1 || mem_wdata_o !== wdata_i[1]) begin
               bad++; $display("FAIL write_data we=%b got=%h exp we=1 data=%h", mem_we_o, mem_wdata_o, wdata_i[1]);
            end
            if (mem_ready_i) begin
               total++;
               if (exp_addr.size() == 0 || k != nbeats + 1) begin
                  bad++; $display("FAIL write_beat cycle=%0d beats=%0d addr=%h", k, nbeats, mem_addr_o);
               end else begin
                  ea = exp_addr.pop_front();
                  if (mem_addr_o !== ea) begin bad++; $display("FAIL write_addr got=%h exp=%h", mem_addr_o, ea); end
               end
               nbeats++; last_k = k;
            end
         end
         if (done_o !== 2'b00) begin
            done_seen = 1; total++;
            if (done_o !== 2'b10 || nbeats != 4 || k != last_k + 1) begin
               bad++; $display("FAIL write_done done=%b beats=%0d cycle=%0d last_beat=%0d exp 10/4/last+1",
                               done_o, nbeats, k, last_k);
            end
         end
         cyc(1); k++;
      end
      total++;
      if (!done_seen) begin bad++; $display("FAIL write_timeout cycles=%0d", k); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g[$];
      logic [1:0] prev_g, eg;
      bit done_flag;
      int ng, cycles;
      prev_g = 2'b00; done_flag = 1; ng = 0; cycles = 0;
      do_reset(2'b11);
      exp_g.push_back(2'b01); exp_g.push_back(2'b10);
      exp_g.push_back(2'b01); exp_g.push_back(2'b10);
      while (ng < 4 && cycles < 200) begin
         cyc(1); cycles++;
         if (prev_g === 2'b00 && gnt_o !== 2'b00) begin
            eg = exp_g.pop_front(); ng++; total++;
            if (gnt_o !== eg || !done_flag) begin
               bad++; $display("FAIL contention_grant n=%0d got=%b exp=%b prior_done=%0d", ng, gnt_o, eg, done_flag);
            end
            done_flag = 0;
         end else if (prev_g !== 2'b00 && gnt_o !== 2'b00) begin
            total++;
            if (gnt_o !== prev_g) begin bad++; $display("FAIL contention_hold got=%b exp=%b", gnt_o, prev_g); end
         end
         if (done_o !== 2'b00) begin
            total++; done_flag = 1;
            if (done_o !== gnt_o) begin bad++; $display("FAIL contention_done got=%b exp=%b", done_o, gnt_o); end
         end
         prev_g = gnt_o;
      end
      total++;
      if (ng != 4) begin bad++; $display("FAIL contention_timeout grants=%0d exp=4", ng); end
      req_i = 2'b00;
      for (int i = 0; i < 60 && gnt_o !== 2'b00; i++) cyc(1);
      total++;
      if (gnt_o !== 2'b00) begin bad++; $display("FAIL contention_drain gnt=%b exp=00", gnt_o); end
   endtask

   task automatic test_backpressure();
      int cycles, stall_left;
      bit stalled, done_seen;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cycles = 0; stall_left = 0; stalled = 0; done_seen = 0;
      req_i = 2'b01; we_i = 2'b00; addr_i[0] = 32'h0000_3000;
      push_burst(32'h0000_3000, 1'b1);
      cyc(1);
      req_i = 2'b00;
      while (!done_seen && cycles < 80) begin
         if (!stalled && mem_req_o && beat_o == BEAT_W'(2)) begin stalled = 1; stall_left = 5; end
         if (stall_left > 0) begin
            mem_ready_i = 1'b0; #1;
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_3008 || beat_o !== BEAT_W'(2) ||
                done_o !== 2'b00 || rvalid_o !== 2'b00) begin
               bad++; $display("FAIL stall_hold req=%b addr=%h beat=%0d done=%b rv=%b exp 1/00003008/2/00/00",
                               mem_req_o, mem_addr_o, beat_o, done_o, rvalid_o);
            end
            stall_left--;
         end
         if (mem_req_o && mem_ready_i) begin
            total++;
            if (exp_addr.size() == 0) begin bad++; $display("FAIL stall_extra_beat addr=%h", mem_addr_o); end
            else begin
               ea = exp_addr.pop_front();
               if (mem_addr_o !== ea) begin bad++; $display("FAIL stall_addr got=%h exp=%h", mem_addr_o, ea); end
            end
         end
         if (rvalid_o !== 2'b00) begin
            total++;
            if (exp_data.size() == 0) begin bad++; $display("FAIL stall_extra_rvalid rv=%b", rvalid_o); end
            else begin
               ed = exp_data.pop_front();
               if (rvalid_o !== 2'b01 || rdata_o !== ed) begin
                  bad++; $display("FAIL stall_data rv=%b got=%h exp=%h", rvalid_o, rdata_o, ed);
               end
            end
         end
         if (done_o !== 2'b00) begin
            done_seen = 1; total++;
            if (done_o !== 2'b01 || exp_addr.size() != 0 || exp_data.size() != 0 || !stalled) begin
               bad++; $display("FAIL stall_done done=%b left=%0d stalled=%0d exp 01/0/1", done_o, exp_addr.size(), stalled);
            end
         end
         cyc(1); cycles++;
      end
      total++;
      if (!done_seen) begin bad++; $display("FAIL stall_timeout cycles=%0d", cycles); end
   endtask

   task automatic test_spurious();
      int cycles;
      bit done_seen;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cycles = 0; done_seen = 0;
      req_i = 2'b00;
      repeat (2) begin
         cyc(1);
         mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
         total++;
         if (rvalid_o !== 2'b00 || rdata_o !== '0 || gnt_o !== 2'b00) begin
            bad++; $display("FAIL spur_idle rv=%b rd=%h gnt=%b exp 00/0/00", rvalid_o, rdata_o, gnt_o);
         end
      end
      req_i = 2'b01; we_i = 2'b00; addr_i[0] = 32'h0000_4000;
      push_burst(32'h0000_4000, 1'b1);
      cyc(1);
      req_i = 2'b00;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
      ea = exp_addr.pop_front();
      total++;
      if (rvalid_o !== 2'b00 || rdata_o !== '0 || mem_req_o !== 1'b1 || beat_o !== '0 || mem_addr_o !== ea) begin
         bad++; $display("FAIL spur_addr rv=%b rd=%h req=%b beat=%0d addr=%h exp 00/0/1/0/%h",
                         rvalid_o, rdata_o, mem_req_o, beat_o, mem_addr_o, ea);
      end
      cyc(1);
      total++;
      if (beat_o !== '0 || mem_req_o !== 1'b0 || rvalid_o !== 2'b00) begin
         bad++; $display("FAIL spur_advance beat=%0d req=%b rv=%b exp 0/0/00", beat_o, mem_req_o, rvalid_o);
      end
      while (!done_seen && cycles < 60) begin
         if (mem_req_o && mem_ready_i) begin
            total++;
            if (exp_addr.size() == 0) begin bad++; $display("FAIL spur_extra_beat addr=%h", mem_addr_o); end
            else begin
               ea = exp_addr.pop_front();
               if (mem_addr_o !== ea) begin bad++; $display("FAIL spur_beat_addr got=%h exp=%h", mem_addr_o, ea); end
            end
         end
         if (rvalid_o !== 2'b00) begin
            total++;
            if (exp_data.size() == 0) begin bad++; $display("FAIL spur_extra_rvalid rv=%b", rvalid_o); end
            else begin
               ed = exp_data.pop_front();
               if (rvalid_o !== 2'b01 || rdata_o !== ed) begin
                  bad++; $display("FAIL spur_data rv=%b got=%h exp=%h", rvalid_o, rdata_o, ed);
               end
            end
         end
         if (done_o !== 2'b00) begin
            done_seen = 1; total++;
            if (done_o !== 2'b01 || exp_data.size() != 0) begin
               bad++; $display("FAIL spur_done done=%b left=%0d exp 01/0", done_o, exp_data.size());
            end
         end
         cyc(1); cycles++;
      end
      total++;
      if (!done_seen) begin bad++; $display("FAIL spur_timeout cycles=%0d", cycles); end
   endtask

   task automatic test_reset_mid();
      bit reached, done_seen;
      reached = 0; done_seen = 0;
      req_i = 2'b01; we_i = 2'b00; addr_i[0] = 32'h0000_5000;
      cyc(1);
      req_i = 2'b00;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (gnt_o === 2'b01 && beat_o === BEAT_W'(1) && mem_req_o === 1'b0) reached = 1;
         else cyc(1);
      end
      total++;
      if (!reached) begin bad++; $display("FAIL rmid_reach beat=%0d gnt=%b", beat_o, gnt_o); end
      rst_i = 1'b0; #1;
      total++;
      if (gnt_o !== 2'b00 || beat_o !== '0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
          mem_addr_o !== '0 || done_o !== 2'b00 || rvalid_o !== 2'b00) begin
         bad++; $display("FAIL rmid_async gnt=%b beat=%0d req=%b we=%b addr=%h done=%b rv=%b exp all zero",
                         gnt_o, beat_o, mem_req_o, mem_we_o, mem_addr_o, done_o, rvalid_o);
      end
      repeat (3) begin
         cyc(1);
         total++;
         if (done_o !== 2'b00 || rvalid_o !== 2'b00 || gnt_o !== 2'b00) begin
            bad++; $display("FAIL rmid_held done=%b rv=%b gnt=%b exp 00/00/00", done_o, rvalid_o, gnt_o);
         end
      end
      req_i = 2'b11; rv_cnt = 0; rst_i = 1'b1;
      cyc(1);
      total++;
      if (gnt_o !== 2'b01) begin bad++; $display("FAIL rmid_first_grant got=%b exp=01", gnt_o); end
      req_i = 2'b00;
      for (int i = 0; i < 60 && gnt_o !== 2'b00; i++) begin
         if (done_o !== 2'b00) done_seen = 1;
         cyc(1);
      end
      total++;
      if (!done_seen || gnt_o !== 2'b00) begin
         bad++; $display("FAIL rmid_drain done_seen=%0d gnt=%b exp 1/00", done_seen, gnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_burst();
      test_contention();
      test_backpressure();
      test_spurious();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single main-memory port between two cache-refill requesters: instruction side (requester 0) and data side (requester 1).
- Each granted transaction is a fixed-length, line-aligned burst of BURST_LEN words, either read (refill) or write (writeback).
- Arbitration is round-robin. The block sequences beats, addresses and handshakes, and signals completion back to the owning cache.
- Sits between the CPU caches and the external memory model.

Parameters:
DATA_WIDTH, 32, word width of memory data
ADDR_WIDTH, 32, byte-address width
BURST_LEN, 4, words per burst (power of two, >=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
req_i  in  2  per-requester request; bit0 instr, bit1 data
we_i  in  2  per-requester write (1) / read (0), sampled at grant
addr_i  in  2xADDR_WIDTH  per-requester base byte address, sampled at grant
wdata_i  in  2xDATA_WIDTH  per-requester write data for current beat
gnt_o  out  2  one-hot owner of the memory port, 0 when idle
beat_o  out  log2(BURST_LEN)  current beat index
rvalid_o  out  2  read beat valid to owner
rdata_o  out  DATA_WIDTH  read data (shared, qualify with rvalid_o)
done_o  out  2  one-cycle burst-complete pulse to owner
mem_req_o  out  1  beat request to memory
mem_we_o  out  1  beat is a write
mem_addr_o  out  ADDR_WIDTH  beat byte address
mem_wdata_o  out  DATA_WIDTH  beat write data
mem_ready_i  in  1  memory accepts current beat this cycle
mem_rvalid_i  in  1  read data returned
mem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (rst_i=0, async): state IDLE, gnt_o=0, beat=0, done_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, last_grant=1 (instr wins first tie). Reset mid-burst aborts the burst; no done_o is produced.
- FSM states: IDLE, ADDR, RDATA, DONE.
- IDLE:
  - Only one req_i bit set: grant that requester.
  - Both set: grant the requester that is not last_grant.
  - On grant, register owner, we, and base = addr_i with low log2(BURST_LEN)+2 bits cleared; beat=0; go to ADDR.
  - Grant is visible on gnt_o the cycle after req_i is first sampled high.
- ADDR:
  - mem_req_o=1, mem_we_o=registered we, mem_addr_o = base + 4*beat.
  - mem_wdata_o = wdata_i[owner] (combinational pass-through).
  - Hold until mem_ready_i=1.
  - Write: on ready, if beat==BURST_LEN-1 go to DONE, else beat++ and stay in ADDR (back-to-back beats allowed).
  - Read: on ready, go to RDATA.
- RDATA:
  - mem_req_o=0. Wait for mem_rvalid_i.
  - On rvalid: rvalid_o[owner]=1 and rdata_o=mem_rdata_i in that same cycle.
  - Then, if last beat, go to DONE; else beat++ and go to ADDR.
  - Only one read beat is outstanding at a time.
- DONE:
  - done_o[owner]=1 for exactly one cycle; last_grant=owner; gnt_o cleared on exit; go to IDLE.
  - Minimum gap between bursts is one idle cycle.
- gnt_o is held constant from grant through DONE inclusive.
- Deasserting req_i mid-burst is ignored; the burst completes.
- addr_i and we_i changes after grant are ignored.
- mem_rvalid_i outside RDATA is ignored, including a cycle coincident with mem_ready_i in ADDR. Memory contract: rvalid arrives at least one cycle after ready.
- rvalid_o=0 and rdata_o=0 when not in RDATA or when mem_rvalid_i=0.
- Beat counter wraps only by FSM exit; it never increments past BURST_LEN-1.
- Address arithmetic is modulo 2^ADDR_WIDTH; a base near the top wraps silently.
- No starvation: with both requesting continuously, grants strictly alternate.

Decomposition:
- Package mem_arbiter_pkg:
  - state enum (IDLE, ADDR, RDATA, DONE)
  - REQ_INSTR=0, REQ_DATA=1
  - BEAT_W = $clog2(BURST_LEN)
  - WORD_BYTES=4
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from req and last_grant, producing a one-hot grant.

Test Plan:
- Single read: req_i=01, addr_i[0]=0x1004, mem_ready_i every cycle, rvalid 2 cycles after each ready.
  - Required: mem_addr_o sequence 0x1000, 0x1004, 0x1008, 0x100C.
  - Four rvalid_o[0] pulses carrying the returned data.
  - done_o[0] pulse once, gnt_o=01 throughout.
- Write burst: req_i=10, we_i[1]=1, addr 0x2000, ready always high.
  - Required: four consecutive mem_req_o cycles with addresses 0x2000..0x200C.
  - mem_wdata_o tracks wdata_i[1] each beat.
  - done_o[1] follows the fourth beat by one cycle.
- Contention: req_i=11 held from reset release.
  - Required: instr granted first, then data, then instr; grants alternate and each done_o precedes the next grant.
- Backpressure: mem_ready_i low 5 cycles during beat 2.
  - Required: mem_req_o, mem_addr_o and beat_o stable throughout; no extra beats; no early done_o.
- Spurious rvalid: mem_rvalid_i high in IDLE and coincident with ready in ADDR.
  - Required: no rvalid_o and no beat advance.
- Reset mid-burst: rst_i low during RDATA of beat 1.
  - Required: immediate IDLE, all outputs 0, no done_o.
  - A new req_i=11 afterwards grants instr first.
